// File: rtl/packet_stream_arbiter_if.sv
// Bundled stream signals for packet_stream_arbiter: SIZE input lanes and one merged output.
// The master modport is the source/sink environment; slave is the arbiter itself.
interface packet_stream_arbiter_if #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [SIZE-1:0]       input_valid;
    logic [SIZE-1:0]       input_last;
    logic [SIZE*WIDTH-1:0] input_data;
    logic [SIZE-1:0]       input_ready;
    logic                  output_valid;
    logic                  output_last;
    logic [WIDTH-1:0]      output_data;
    logic [CW-1:0]         output_channel;
    logic                  output_ready;

    modport master (
        output input_valid, input_last, input_data, output_ready,
        input  input_ready, output_valid, output_last, output_data, output_channel
    );

    modport slave (
        input  input_valid, input_last, input_data, output_ready,
        output input_ready, output_valid, output_last, output_data, output_channel
    );
endinterface

// File: rtl/packet_stream_arbiter.sv
// Round-robin merge of SIZE valid/ready streams into one registered output stream,
// optionally holding the grant on a channel until its packet's last beat is accepted.
module packet_stream_arbiter #(
    parameter int unsigned SIZE           = 4,
    parameter int unsigned WIDTH          = 8,
    parameter bit          LOCK_ON_PACKET = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    packet_stream_arbiter_if.slave bus
);
    localparam int unsigned CW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t           state;
    logic [CW-1:0]    pointer;
    logic [CW-1:0]    locked_channel;
    logic             out_valid;
    logic             out_last;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_channel;

    logic             load_enable;
    logic             sel_found;
    logic [CW-1:0]    sel_idx;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic [SIZE-1:0]  ready;
    logic             accept;
    logic [CW-1:0]    next_pointer;

    always_comb begin
        load_enable = !out_valid || bus.output_ready;
        sel_found   = 1'b0;
        sel_idx     = '0;
        if (state == LOCKED) begin
            // A locked channel owns the grant even while it has nothing to send.
            sel_found = 1'b1;
            sel_idx   = locked_channel;
        end else begin
            // Two ascending passes give the rotated scan pointer..SIZE-1, then 0..pointer-1.
            for (int unsigned i = 0; i < SIZE; i++) begin
                if (!sel_found && bus.input_valid[i] && (i >= 32'(pointer))) begin
                    sel_found = 1'b1;
                    sel_idx   = CW'(i);
                end
            end
            for (int unsigned i = 0; i < SIZE; i++) begin
                if (!sel_found && bus.input_valid[i] && (i < 32'(pointer))) begin
                    sel_found = 1'b1;
                    sel_idx   = CW'(i);
                end
            end
        end

        sel_last = 1'b0;
        sel_data = '0;
        ready    = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (CW'(i) == sel_idx) begin
                sel_last = bus.input_last[i];
                sel_data = bus.input_data[i*WIDTH +: WIDTH];
                ready[i] = sel_found && load_enable && !reset;
            end
        end

        accept       = |(ready & bus.input_valid);
        next_pointer = (sel_idx == CW'(SIZE - 1)) ? '0 : CW'(sel_idx + 1'b1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= UNLOCKED;
            pointer        <= '0;
            locked_channel <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            out_data       <= '0;
            out_channel    <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_last    <= sel_last;
            out_data    <= sel_data;
            out_channel <= sel_idx;
            if (sel_last || !LOCK_ON_PACKET) begin
                state   <= UNLOCKED;
                pointer <= next_pointer;
            end else begin
                state          <= LOCKED;
                locked_channel <= sel_idx;
            end
        end else if (bus.output_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.input_ready    = ready;
    assign bus.output_valid   = out_valid;
    assign bus.output_last    = out_last;
    assign bus.output_data    = out_data;
    assign bus.output_channel = out_channel;
endmodule

// File: tb/tb_packet_stream_arbiter.sv
// Bench for packet_stream_arbiter (SIZE=4, WIDTH=8, LOCK_ON_PACKET=1): vector table,
// hand-written multi-cycle sequences, then random traffic against a reference model.
module tb_packet_stream_arbiter;
    localparam int unsigned SIZE  = 4;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    packet_stream_arbiter_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();

    packet_stream_arbiter #(
        .SIZE(SIZE),
        .WIDTH(WIDTH),
        .LOCK_ON_PACKET(1'b1)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       r;
        logic [3:0] v;
        logic [3:0] l;
        logic       ord;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [1:0] e_ch;
        logic       chk_out;
    } vec_t;

    vec_t tbl [10];

    // Source-side rule: a valid beat that was not accepted must be held unchanged.
    logic        hold_en = 1'b0;
    logic        p_rst   = 1'b1;
    logic [3:0]  p_v     = '0;
    logic [3:0]  p_l     = '0;
    logic [3:0]  p_acc   = '0;
    logic [31:0] p_d     = '0;
    always @(posedge clk) begin
        if (hold_en && !p_rst && !rst) begin
            for (int c = 0; c < 4; c++) begin
                if (p_v[c] && !p_acc[c]) begin
                    assert (bus.input_valid[c] && bus.input_last[c] == p_l[c] &&
                            bus.input_data[c*8 +: 8] == p_d[c*8 +: 8])
                    else $error("FAIL src_hold ch%0d changed before acceptance", c);
                end
            end
        end
        p_rst <= rst;
        p_v   <= bus.input_valid;
        p_l   <= bus.input_last;
        p_d   <= bus.input_data;
        p_acc <= bus.input_valid & bus.input_ready;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Entered and left at posedge+1: drive inputs, check at negedge, advance one cycle.
    task automatic cyc(input logic r, input logic [3:0] v, input logic [3:0] l,
                       input logic [31:0] d, input logic ord, input logic [3:0] e_rdy,
                       input logic e_ov, input logic [1:0] e_ch, input logic e_last,
                       input logic [7:0] e_data, input logic chk_out, input string name);
        rst                = r;
        bus.input_valid    = v;
        bus.input_last     = l;
        bus.input_data     = d;
        bus.output_ready   = ord;
        @(negedge clk);
        chk({name, " ready"}, 32'(bus.input_ready), 32'(e_rdy));
        if (chk_out) begin
            chk({name, " ovalid"}, 32'(bus.output_valid), 32'(e_ov));
            if (e_ov) begin
                chk({name, " ochan"}, 32'(bus.output_channel), 32'(e_ch));
                chk({name, " olast"}, 32'(bus.output_last), 32'(e_last));
                chk({name, " odata"}, 32'(bus.output_data), 32'(e_data));
            end
        end
        next_cycle();
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.input_valid  = '0;
        bus.input_last   = '0;
        bus.input_data   = '0;
        bus.output_ready = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // Reference model state for the random phase
    bit          m_ov, m_last, m_locked;
    int          m_ptr, m_lc, m_ch, g, cidx;
    logic [7:0]  m_data;
    logic [3:0]  sv, sl, e_rdy, got_rdy;
    logic [7:0]  sd [4];
    logic        r_rnd, ord, le;

    initial begin
        bus.input_valid  = '1;
        bus.input_last   = '0;
        bus.input_data   = '0;
        bus.output_ready = 1'b1;
        #1;

        //          r     v        l        ord   e_rdy    ov    ch  chk_out
        tbl[0] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[1] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};
        tbl[2] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1};
        tbl[3] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b1};
        tbl[4] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b1};
        tbl[5] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 1'b1};
        tbl[6] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 1'b1};
        tbl[7] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b1};
        tbl[8] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1};
        tbl[9] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].l, 32'hA3A2A1A0, tbl[i].ord, tbl[i].e_rdy,
                tbl[i].e_ov, tbl[i].e_ch, 1'b1, 8'hA0 + 8'(tbl[i].e_ch), tbl[i].chk_out,
                $sformatf("tbl%0d", i));
        end

        // Three-beat packet on channel 2 while 0 and 3 wait
        do_reset();
        cyc(0, 4'b0010, 4'b0010, 32'h00001100, 1, 4'b0010, 0, 0, 0, 8'h00, 1, "pkt c1");
        cyc(0, 4'b1101, 4'b1001, 32'h31210001, 1, 4'b0100, 1, 1, 1, 8'h11, 1, "pkt c2");
        cyc(0, 4'b1101, 4'b1001, 32'h31220001, 1, 4'b0100, 1, 2, 0, 8'h21, 1, "pkt c3");
        cyc(0, 4'b1101, 4'b1101, 32'h31230001, 1, 4'b0100, 1, 2, 0, 8'h22, 1, "pkt c4");
        cyc(0, 4'b1001, 4'b1001, 32'h31000001, 1, 4'b1000, 1, 2, 1, 8'h23, 1, "pkt c5");
        cyc(0, 4'b0001, 4'b0001, 32'h00000001, 1, 4'b0001, 1, 3, 1, 8'h31, 1, "pkt c6");
        cyc(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 0, 1, 8'h01, 1, "pkt c7");
        cyc(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 0, 0, 8'h00, 1, "pkt c8");

        // Output back-pressure hold, then drain and load in one cycle
        do_reset();
        cyc(0, 4'b0001, 4'b0001, 32'h0000005A, 1, 4'b0001, 0, 0, 0, 8'h00, 1, "stall c1");
        for (int i = 0; i < 5; i++)
            cyc(0, 4'b0010, 4'b0010, 32'h00006B5A, 0, 4'b0000, 1, 0, 1, 8'h5A, 1,
                $sformatf("stall hold%0d", i));
        cyc(0, 4'b0010, 4'b0010, 32'h00006B5A, 1, 4'b0010, 1, 0, 1, 8'h5A, 1, "stall rel");
        cyc(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 1, 1, 8'h6B, 1, "stall next");
        cyc(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 0, 0, 8'h00, 1, "stall empty");

        // Lock on channel 1 survives its idle gap while channel 0 waits
        do_reset();
        cyc(0, 4'b0010, 4'b0000, 32'h00004100, 1, 4'b0010, 0, 0, 0, 8'h00, 1, "lock c1");
        cyc(0, 4'b0001, 4'b0001, 32'h00000001, 1, 4'b0010, 1, 1, 0, 8'h41, 1, "lock c2");
        for (int i = 0; i < 3; i++)
            cyc(0, 4'b0001, 4'b0001, 32'h00000001, 1, 4'b0010, 0, 0, 0, 8'h00, 1,
                $sformatf("lock idle%0d", i));
        cyc(0, 4'b0011, 4'b0011, 32'h00004201, 1, 4'b0010, 0, 0, 0, 8'h00, 1, "lock end");
        cyc(0, 4'b0001, 4'b0001, 32'h00000001, 1, 4'b0001, 1, 1, 1, 8'h42, 1, "lock ch0");
        cyc(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 0, 1, 8'h01, 1, "lock out0");

        // Reset while locked on channel 3 with a beat held
        do_reset();
        cyc(0, 4'b1000, 4'b0000, 32'h71000000, 1, 4'b1000, 0, 0, 0, 8'h00, 1, "rstlk c1");
        cyc(0, 4'b1000, 4'b0000, 32'h72000000, 1, 4'b1000, 1, 3, 0, 8'h71, 1, "rstlk c2");
        cyc(1, 4'b1111, 4'b1111, 32'h7F2F1F0F, 1, 4'b0000, 1, 3, 0, 8'h72, 1, "rstlk rst");
        cyc(0, 4'b1111, 4'b1111, 32'h7F2F1F0F, 1, 4'b0001, 0, 0, 0, 8'h00, 1, "rstlk rel");
        cyc(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 0, 1, 8'h0F, 1, "rstlk out");

        // Random traffic against the reference model
        do_reset();
        hold_en  = 1'b1;
        m_ov     = 0; m_last = 0; m_locked = 0;
        m_ptr    = 0; m_lc = 0; m_ch = 0; m_data = '0;
        sv       = '0; sl = '0;
        for (int c = 0; c < 4; c++) sd[c] = '0;
        for (int n = 0; n < 2000; n++) begin
            r_rnd = ($urandom_range(0, 199) == 0);
            for (int c = 0; c < 4; c++) begin
                if (!sv[c] && $urandom_range(0, 2) == 0) begin
                    sv[c] = 1'b1;
                    sl[c] = ($urandom_range(0, 2) == 0);
                    sd[c] = 8'($urandom);
                end
            end
            ord              = ($urandom_range(0, 3) != 0);
            rst              = r_rnd;
            bus.input_valid  = sv;
            bus.input_last   = sl;
            bus.input_data   = {sd[3], sd[2], sd[1], sd[0]};
            bus.output_ready = ord;

            le = !m_ov || ord;
            g  = -1;
            if (!r_rnd) begin
                if (m_locked) g = m_lc;
                else begin
                    for (int k = 0; k < 4; k++) begin
                        cidx = (m_ptr + k) % 4;
                        if (g < 0 && sv[cidx]) g = cidx;
                    end
                end
            end
            e_rdy = (g >= 0 && le) ? (4'b0001 << g) : 4'b0000;

            @(negedge clk);
            chk("rnd ready", 32'(bus.input_ready), 32'(e_rdy));
            chk("rnd ovalid", 32'(bus.output_valid), 32'(m_ov));
            if (m_ov) begin
                chk("rnd ochan", 32'(bus.output_channel), 32'(m_ch));
                chk("rnd olast", 32'(bus.output_last), 32'(m_last));
                chk("rnd odata", 32'(bus.output_data), 32'(m_data));
            end
            got_rdy = bus.input_ready;

            if (r_rnd) begin
                m_ov = 0; m_last = 0; m_data = '0; m_ch = 0; m_ptr = 0; m_locked = 0;
            end else if (g >= 0 && le && sv[g]) begin
                m_ov   = 1;
                m_ch   = g;
                m_last = sl[g];
                m_data = sd[g];
                if (sl[g]) begin
                    m_ptr    = (g + 1) % 4;
                    m_locked = 0;
                end else begin
                    m_locked = 1;
                    m_lc     = g;
                end
            end else if (ord) begin
                m_ov = 0;
            end
            if (!r_rnd) sv = sv & ~(got_rdy & sv);
            next_cycle();
        end
        hold_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
